// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader writing 32-bit words into instruction memory; ports: rx byte handshake in, mem write strobe/addr/data out, cpu_hold and load status out
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [6:0]        words_loaded
);
    typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERROR} state_t;
    localparam logic [7:0] MAX_B = 8'(MAX_WORDS);
    state_t state, next;
    logic acc;
    logic [1:0] byte_idx;
    logic [6:0] word_idx, count;
    logic [7:0] csum;
    logic [23:0] shreg;
    assign acc = rx_valid && rx_ready;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? COUNT : IDLE;
            COUNT:   next = !acc ? COUNT : (rx_data == 8'd0 || rx_data > MAX_B) ? ERROR : DATA;
            DATA:    next = (acc && byte_idx == 2'd3 && word_idx + 7'd1 == count) ? CHECK : DATA;
            CHECK:   next = !acc ? CHECK : (rx_data == csum) ? DONE : ERROR;
            default: next = start ? COUNT : state;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rx_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            byte_idx     <= '0;
            word_idx     <= '0;
            count        <= '0;
            csum         <= '0;
            shreg        <= '0;
        end else begin
            state      <= next;
            rx_ready   <= next == COUNT || next == DATA || next == CHECK;
            cpu_hold   <= next != DONE;
            load_done  <= next == DONE;
            load_error <= next == ERROR;
            mem_we     <= 1'b0;
            if (state == COUNT && next == DATA) begin
                count        <= rx_data[6:0];
                word_idx     <= '0;
                byte_idx     <= '0;
                csum         <= '0;
                words_loaded <= '0;
            end
            if (state == DATA && acc) begin
                shreg    <= {shreg[15:0], rx_data};
                csum     <= csum ^ rx_data;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    mem_we       <= 1'b1;
                    mem_addr     <= ADDR_W'({word_idx, 2'b00});
                    mem_wdata    <= {shreg, rx_data};
                    word_idx     <= word_idx + 7'd1;
                    words_loaded <= words_loaded + 7'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader framing, checksum, range, throttling and reset behaviour
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset, start, rx_valid, rx_ready, mem_we, cpu_hold, load_done, load_error;
    logic [7:0] rx_data, mem_addr, last_addr;
    logic [31:0] mem_wdata;
    logic [6:0] words_loaded;
    logic [31:0] prog [64];
    logic [39:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
    );

    task tick();
        logic [39:0] e;
        @(negedge clk);
        if (mem_we) begin
            checks++;
            last_addr = mem_addr;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%h data=%h expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e)
                    begin errors++; $display("FAIL write addr/data=%h/%h expected %h/%h", mem_addr, mem_wdata, e[39:32], e[31:0]); end
            end
        end
    endtask

    task pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_data = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin tick(); n++; end
        if (!rx_ready) begin
            checks++; errors++;
            $display("FAIL rx_ready_timeout byte=%h rx_ready=%b expected 1", b, rx_ready);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task send_frame(input logic [7:0] cnt, input int n, input logic [7:0] delta, input int gap, input bit poke);
        logic [7:0] cs, b;
        cs = 8'h00;
        send_byte(cnt, gap);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) begin
                b = prog[i][31-8*k -: 8];
                cs ^= b;
                if (k == 3) exp_q.push_back({8'(i * 4), prog[i]});
                if (poke && i == 0 && k == 2) pulse_start();
                if (poke && i == 1 && k == 1) start = 1'b1;
                send_byte(b, gap);
                start = 1'b0;
            end
        send_byte(cs ^ delta, gap);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL writes_missing pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task test_reset();
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        checks++; if ({cpu_hold, rx_ready, mem_we, load_done, load_error} !== 5'b10000)
            begin errors++; $display("FAIL reset hold/rdy/we/done/err=%b expected 10000", {cpu_hold, rx_ready, mem_we, load_done, load_error}); end
        checks++; if (words_loaded !== 7'd0 || mem_addr !== 8'h00 || mem_wdata !== 32'h0)
            begin errors++; $display("FAIL reset words=%0d addr=%h data=%h expected 0/00/0", words_loaded, mem_addr, mem_wdata); end
        reset = 1'b0;
        rx_valid = 1'b1; rx_data = 8'h02;
        repeat (4) tick();
        checks++; if (rx_ready !== 1'b0 || cpu_hold !== 1'b1)
            begin errors++; $display("FAIL idle_hold rx_ready=%b cpu_hold=%b expected 0/1", rx_ready, cpu_hold); end
        rx_valid = 1'b0;
    endtask

    task test_good_load(input int gap, input bit poke);
        prog[0] = 32'hE2110000; prog[1] = 32'hE0805183;
        pulse_start();
        send_frame(8'h02, 2, 8'h00, gap, poke);
        checks++; if ({load_done, load_error, cpu_hold} !== 3'b100)
            begin errors++; $display("FAIL good gap=%0d done/err/hold=%b expected 100", gap, {load_done, load_error, cpu_hold}); end
        checks++; if (words_loaded !== 7'd2 || rx_ready !== 1'b0)
            begin errors++; $display("FAIL good gap=%0d words=%0d rx_ready=%b expected 2/0", gap, words_loaded, rx_ready); end
    endtask

    task test_bad_checksum();
        pulse_start();
        checks++; if (load_done !== 1'b0 || cpu_hold !== 1'b1)
            begin errors++; $display("FAIL restart done=%b hold=%b expected 0/1", load_done, cpu_hold); end
        send_frame(8'h02, 2, 8'h03, 0, 1'b0);
        checks++; if ({load_done, load_error, cpu_hold} !== 3'b011)
            begin errors++; $display("FAIL bad_csum done/err/hold=%b expected 011", {load_done, load_error, cpu_hold}); end
        checks++; if (words_loaded !== 7'd2)
            begin errors++; $display("FAIL bad_csum words=%0d expected 2", words_loaded); end
        test_good_load(0, 1'b0);
    endtask

    task test_count_range();
        pulse_start();
        send_byte(8'h00, 0);
        checks++; if (load_error !== 1'b1 || rx_ready !== 1'b0 || words_loaded !== 7'd2)
            begin errors++; $display("FAIL count_zero err=%b rdy=%b words=%0d expected 1/0/2", load_error, rx_ready, words_loaded); end
        repeat (2) tick();
        pulse_start();
        checks++; if (load_error !== 1'b0 || rx_ready !== 1'b1)
            begin errors++; $display("FAIL restart_err err=%b rdy=%b expected 0/1", load_error, rx_ready); end
        send_byte(8'h41, 0);
        checks++; if (load_error !== 1'b1 || load_done !== 1'b0 || cpu_hold !== 1'b1)
            begin errors++; $display("FAIL count_65 err=%b done=%b hold=%b expected 1/0/1", load_error, load_done, cpu_hold); end
    endtask

    task test_full_and_reset();
        for (int i = 0; i < 64; i++) prog[i] = $urandom;
        pulse_start();
        send_frame(8'h40, 64, 8'h00, 0, 1'b0);
        checks++; if (last_addr !== 8'hFC || words_loaded !== 7'd64 || load_done !== 1'b1)
            begin errors++; $display("FAIL full last_addr=%h words=%0d done=%b expected FC/64/1", last_addr, words_loaded, load_done); end
        prog[0] = 32'hE2110000;
        pulse_start();
        exp_q.push_back({8'h00, prog[0]});
        send_byte(8'h02, 0);
        for (int k = 0; k < 4; k++) send_byte(prog[0][31-8*k -: 8], 0);
        checks++; if (words_loaded !== 7'd1)
            begin errors++; $display("FAIL midload words=%0d expected 1", words_loaded); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({cpu_hold, rx_ready, mem_we, load_done, load_error} !== 5'b10000 || words_loaded !== 7'd0 || mem_addr !== 8'h00)
            begin errors++; $display("FAIL async_reset flags=%b words=%0d addr=%h expected 10000/0/00", {cpu_hold, rx_ready, mem_we, load_done, load_error}, words_loaded, mem_addr); end
        tick();
        reset = 1'b0;
        exp_q.delete();
        test_good_load(0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_good_load(0, 1'b0);
        test_bad_checksum();
        test_count_range();
        test_good_load(3, 1'b1);
        test_full_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream loader that fills the instruction memory before the pipeline runs. It is the write side of the instruction memory, which the IF stage reads through PC_current[7:0].
- Accepts a framed program image over a valid/ready byte interface and assembles 32-bit words. Writes them to consecutive word addresses and verifies an XOR checksum.
- Holds the pipeline (PC and IF/ID enables) until a load completes successfully.

Parameters:
- ADDR_W, 8, instruction memory byte-address width; matches PC_current[7:0].
- MAX_WORDS, 64, maximum program length in words (2^ADDR_W / 4).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_W  byte address of the word being written; always word-aligned.
- mem_wdata  output  32  instruction word.
- cpu_hold  output  1  pipeline hold; the top level drives PC_enable and IF_ID_Enable from ~cpu_hold.
- load_done  output  1  last load succeeded.
- load_error  output  1  last load failed.
- words_loaded  output  7  count of words written in the current/last load.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, load_done=0, load_error=0, words_loaded=0.
  - Internal byte index, word index and checksum are cleared.
  - Memory contents already written are not cleared.
- Byte transfer: a byte is accepted on a rising edge when rx_valid && rx_ready. rx_ready is a registered output, high only in COUNT, DATA and CHECK. Gaps in rx_valid of any length are allowed.
- Frame format: one count byte N (1..MAX_WORDS), then 4N data bytes, then one checksum byte.
  - Data bytes are most-significant first: byte 0 is word[31:24], byte 3 is word[7:0].
  - Checksum is the XOR of all 4N data bytes; the count byte is excluded.
- States:
  - IDLE: cpu_hold=1. start -> COUNT.
  - COUNT: on the accepted byte, if N==0 or N>MAX_WORDS go to ERROR; otherwise latch N, clear word index, checksum and words_loaded, and go to DATA.
  - DATA: each accepted byte shifts into the assembly register and XORs into the checksum.
    - On the 4th byte of a word, the next cycle has mem_we=1 for exactly one cycle, with mem_addr=word_index*4 and mem_wdata=the assembled word.
    - words_loaded increments in that same cycle.
    - After the 4N-th byte, go to CHECK. The final write strobe overlaps the first CHECK cycle.
  - CHECK: on the accepted byte, if it equals the checksum go to DONE, else go to ERROR.
  - DONE: load_done=1, cpu_hold=0, rx_ready=0.
  - ERROR: load_error=1, cpu_hold=1, rx_ready=0.
- Restart: start in DONE or ERROR goes to COUNT and clears load_done and load_error. cpu_hold returns to 1 on the same edge.
- start is ignored while in COUNT, DATA or CHECK.
- A start pulse coincident with an accepted byte is ignored.
- mem_addr never wraps: a word index of MAX_WORDS is unreachable because N is range-checked.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset check: assert reset for 3 cycles.
  - Expected: cpu_hold=1, rx_ready=0, mem_we=0, load_done=0, load_error=0, words_loaded=0.
  - Expected: IDLE holds with rx_valid=1 and no start.
- Good load: start, then bytes 02, E2 11 00 00, E0 80 51 83, 41.
  - Expected: mem_we pulses with addr 0x00/data E2110000, then addr 0x04/data E0805183.
  - Expected: load_done=1, cpu_hold=0, words_loaded=2.
- Bad checksum: same frame with final byte 42.
  - Expected: both words written, load_error=1, load_done=0, cpu_hold=1.
  - Expected: a subsequent start plus the good frame gives load_done=1.
- Count range: count byte 00 -> ERROR on the next edge with no mem_we. Count byte 41 (65) -> ERROR.
- Throttling and ignored start:
  - Stimulus: rx_valid deasserted for 3 cycles between every byte; start pulsed during DATA.
  - Expected: identical writes and result to the good load.
- Full size and mid-load reset:
  - Stimulus: 64-word frame.
  - Expected: last write at addr 0xFC, words_loaded=64, load_done=1.
  - Stimulus: reset after the 5th byte of another load.
  - Expected: outputs take reset values immediately, then a fresh load succeeds.
